data_mem_resp: RTL and testbench
================================

# data_mem_resp

Responder side of the CPU's data-memory interface: accepts one load/store request at a time from the memory pipeline stage, performs byte/half/word stores with lane masking and loads with sign/zero extension, and returns a response after a fixed, parameterised latency. It replaces the zero-latency combinational memory model so the pipeline can be exercised against a realistic multi-cycle memory. It owns a word-organised RAM and the state machine that sequences each request.

## Interface
- ADDR_WIDTH, 12, byte-address bits decoded; RAM holds 2^(ADDR_WIDTH-2) 32-bit words
- LATENCY, 2, cycles from accept edge to the response cycle; legal range 1..15
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_req_valid  input  1  request present
- o_req_ready  output  1  responder can accept; high only in IDLE
- i_addr  input  32  byte address; bits above ADDR_WIDTH-1 ignored (wrap)
- i_wr_en  input  1  1 = store, 0 = load
- i_wr_val  input  32  store data, right-aligned (data_val)
- i_l_s_sel  input  3  funct3 width select (l_s_sel): 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- o_rsp_valid  output  1  one-cycle response strobe
- o_rd_val  output  32  load result, extended; 0 for stores and faults
- o_misaligned  output  1  valid with o_rsp_valid: request was misaligned or used an illegal select

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: o_req_ready=1. Accept on i_req_valid && o_req_ready at a rising edge; request fields are latched on that edge.
- Accept edge: if LATENCY==1, go to RESP; otherwise go to WAIT with counter = LATENCY-2.
- WAIT: decrement each cycle; go to RESP on the edge where counter==0.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. No accept in WAIT or RESP.
- Store commit: RAM is written on the accept edge, so a load accepted afterwards always sees the new data.
  - Byte: lane addr[1:0] gets i_wr_val[7:0].
  - Half: lanes {addr[1],0}/+1 get i_wr_val[15:0] (little-endian).
  - Word: all four lanes.
  - Unselected lanes are unchanged.
- Load data: the word is read and extended on the edge entering RESP.
  - 000: sign-extend the selected byte. 100: zero-extend it.
  - 001: sign-extend the selected half. 101: zero-extend it.
  - 010: full word.
- Fault: half with addr[0]=1, word with addr[1:0]!=0, or select 011/110/111.
  - No RAM write occurs.
  - Response: o_misaligned=1, o_rd_val=0.
- Stores respond with o_rd_val=0 and o_misaligned=0 unless faulted.
- Address index = addr[ADDR_WIDTH-1:2]; higher bits are ignored, so the address wraps.

## Timing
- Reset (edge with i_rst=1):
  - State goes to IDLE and the counter clears.
  - Outputs next cycle: o_req_ready=1, o_rsp_valid=0, o_rd_val=0, o_misaligned=0.
  - RAM contents are not cleared (simulation initialises them to 0).
- Reset mid-request (WAIT or RESP): the response is dropped and no strobe follows. A store already committed at accept stays committed.
- Reset wins over a simultaneous accept: nothing is latched and no write occurs.
- Response cycle = accept edge + LATENCY cycles. The earliest next accept is the edge ending RESP, giving throughput of one request per LATENCY+1 cycles.
- o_rd_val and o_misaligned hold their values outside RESP; the consumer samples them only with o_rsp_valid.
- i_req_valid held high through WAIT/RESP is not re-accepted until IDLE. The requester holds its fields stable until accepted.

## Test plan
- Reset then idle → o_req_ready=1, o_rsp_valid=0, o_rd_val=0 for 5 cycles.
- LATENCY=2: store word 0xDEADBEEF @0x10 (accept cycle 0), then load word @0x10 → first o_rsp_valid in cycle 2 (rd 0), second strobe 2 cycles after its accept with o_rd_val=0xDEADBEEF; o_req_ready low between.
- Byte lanes: store byte 0x80 @0x11 over 0xDEADBEEF; load byte @0x11 → 0xFFFFFF80; load ubyte → 0x00000080; load word → 0xDEAD80EF; load half @0x12 → 0xFFFFDEAD.
- Misaligned: store word 0x12345678 @0x22 → o_misaligned=1, o_rd_val=0; subsequent load word @0x20 returns prior contents (0 after init); load half @0x13 also faults; select 011 faults.
- Wrap: ADDR_WIDTH=12, store word 0xA5A5A5A5 @0x1004 → load word @0x004 returns 0xA5A5A5A5.
- Reset mid-request: LATENCY=4, accept store 0x11223344 @0x30, assert i_rst in WAIT → no o_rsp_valid; after reset, load @0x30 → 0x11223344.

Source files
------------

// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM with byte/half/word access, fixed-latency
// response sequenced by a small IDLE/WAIT/RESP state machine.
module data_mem_resp #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_val,
    input  logic [2:0]  i_l_s_sel,
    output logic        o_rsp_valid,
    output logic [31:0] o_rd_val,
    output logic        o_misaligned
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              sel_q;
    logic                    wr_q;
    logic                    fault_q;
    logic                    rsp_valid_q;
    logic [31:0]             rd_val_q;
    logic                    mis_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    accept;
    logic                    fault_d;
    logic [3:0]              be_d;
    logic [31:0]             wdata_d;
    logic [31:0]             rd_acc_d;
    logic [31:0]             rd_wait_d;
    logic                    unused_addr;

    function automatic logic is_fault(logic [1:0] a, logic [2:0] s);
        case (s)
            3'b000, 3'b100: is_fault = 1'b0;
            3'b001, 3'b101: is_fault = a[0];
            3'b010:         is_fault = |a;
            default:        is_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend(logic [31:0] w, logic [1:0] a,
                                           logic [2:0] s);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (s)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b100:  extend = {24'b0, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b101:  extend = {16'b0, h};
            3'b010:  extend = w;
            default: extend = 32'b0;
        endcase
    endfunction

    assign unused_addr = ^i_addr[31:ADDR_WIDTH];
    assign accept      = i_req_valid && (state_q == IDLE);
    assign fault_d     = is_fault(i_addr[1:0], i_l_s_sel);

    always_comb begin
        be_d    = 4'b0000;
        wdata_d = i_wr_val;
        case (i_l_s_sel[1:0])
            2'b00: begin
                be_d    = 4'b0001 << i_addr[1:0];
                wdata_d = {4{i_wr_val[7:0]}};
            end
            2'b01: begin
                be_d    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{i_wr_val[15:0]}};
            end
            default: be_d = 4'b1111;
        endcase
    end

    // Read paths: straight from the request when entering RESP on the accept
    // edge, otherwise from the latched request.
    assign rd_acc_d = (i_wr_en || fault_d) ? 32'b0 :
                      extend(mem_q[i_addr[ADDR_WIDTH-1:2]], i_addr[1:0],
                             i_l_s_sel);
    assign rd_wait_d = (wr_q || fault_q) ? 32'b0 :
                       extend(mem_q[addr_q[ADDR_WIDTH-1:2]], addr_q[1:0],
                              sel_q);

    // Store commits on the accept edge; RAM itself is never reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept && i_wr_en && !fault_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) begin
                    mem_q[i_addr[ADDR_WIDTH-1:2]][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            sel_q       <= 3'b0;
            wr_q        <= 1'b0;
            fault_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_val_q    <= 32'b0;
            mis_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (i_req_valid) begin
                        addr_q  <= i_addr[ADDR_WIDTH-1:0];
                        sel_q   <= i_l_s_sel;
                        wr_q    <= i_wr_en;
                        fault_q <= fault_d;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rd_val_q    <= rd_acc_d;
                            mis_q       <= fault_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rd_val_q    <= rd_wait_d;
                        mis_q       <= fault_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = (state_q == IDLE);
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rd_val     = rd_val_q;
    assign o_misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: directed cases plus random traffic
// against a byte-array memory model.
module tb_data_mem_resp;

    localparam int AW  = 12;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wr_val;
    logic [2:0]  sel;
    logic        rsp_valid;
    logic [31:0] rd_val;
    logic        mis;

    data_mem_resp #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_addr       (addr),
        .i_wr_en      (wr_en),
        .i_wr_val     (wr_val),
        .i_l_s_sel    (sel),
        .o_rsp_valid  (rsp_valid),
        .o_rd_val     (rd_val),
        .o_misaligned (mis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          acc;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] bm [4096];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: byte-addressed memory of 2^AW bytes, spec rules applied directly.
    function automatic void model(input logic [31:0] a, input logic w,
                                  input logic [31:0] v, input logic [2:0] s,
                                  output logic [31:0] rd, output logic m);
        int          ba;
        int          n;
        longint      x;
        ba = int'(a % 32'(4096));
        n  = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
        if (s == 3'b011 || s == 3'b110 || s == 3'b111 || (ba % n) != 0) begin
            rd = 32'b0;
            m  = 1'b1;
            return;
        end
        m = 1'b0;
        if (w) begin
            for (int i = 0; i < n; i++) bm[ba + i] = 8'(v >> (8 * i));
            rd = 32'b0;
        end else begin
            x = 0;
            for (int i = 0; i < n; i++) x += longint'(bm[ba + i]) << (8 * i);
            if (!s[2] && n < 4 && x >= (longint'(1) << (8 * n - 1)))
                x -= longint'(1) << (8 * n);
            rd = 32'(x);
        end
    endfunction

    // Monitor: pops one expectation per strobe; ready must stay low in flight.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() != 0) chk("ready_busy", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_cycle", 32'(cyc), 32'(q[0].acc + LAT));
                    chk("rd_val", rd_val, q[0].rd);
                    chk("misaligned", 32'(mis), 32'(q[0].mis));
                    void'(q.pop_front());
                end
            end else if (q.size() != 0 && cyc > q[0].acc + LAT + 4) begin
                chk("rsp_timeout", 32'(rsp_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic w,
                          input logic [31:0] v, input logic [2:0] s);
        int   n;
        logic rdy;
        exp_t e;
        n = 0;
        @(negedge clk);
        addr = a; wr_en = w; wr_val = v; sel = s; req_valid = 1'b1;
        forever begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) begin
                model(a, w, v, s, e.rd, e.mis);
                e.acc = cyc;
                q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'(rdy), 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        for (int i = 0; i < 4096; i++) bm[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; addr = '0; wr_en = 1'b0;
        wr_val = '0; sel = 3'b010;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_ready", 32'(req_ready), 32'd1);
            chk("reset_rsp", 32'(rsp_valid), 32'd0);
            chk("reset_rd", rd_val, 32'd0);
            chk("reset_mis", 32'(mis), 32'd0);
        end

        do_req(32'h10, 1, 32'hDEADBEEF, 3'b010);
        do_req(32'h10, 0, 32'h0, 3'b010);
        do_req(32'h11, 1, 32'h00000080, 3'b000);
        do_req(32'h11, 0, 32'h0, 3'b000);
        do_req(32'h11, 0, 32'h0, 3'b100);
        do_req(32'h10, 0, 32'h0, 3'b010);
        do_req(32'h12, 0, 32'h0, 3'b001);
        do_req(32'h22, 1, 32'h12345678, 3'b010);
        do_req(32'h20, 0, 32'h0, 3'b010);
        do_req(32'h13, 0, 32'h0, 3'b001);
        do_req(32'h10, 0, 32'h0, 3'b011);
        do_req(32'h1004, 1, 32'hA5A5A5A5, 3'b010);
        do_req(32'h004, 0, 32'h0, 3'b010);
        idle(3);

        // Reset in WAIT drops the response; the committed store survives.
        do_req(32'h30, 1, 32'h11223344, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        // Reset also wins over a simultaneous accept: this store must vanish.
        addr = 32'h30; wr_en = 1'b1; wr_val = 32'hBAD0BAD0; sel = 3'b010;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        do_req(32'h30, 0, 32'h0, 3'b010);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0,
                 6'h0, 6'($urandom_range(0, 63))};
            do_req(a, 1'($urandom), $urandom, 3'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(1);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
